// File: rtl/imem_arbiter.sv
// Boot sequencer and single-port instruction-memory arbiter (fetch vs host loader); build with IMEM_ARB_FAIRNESS_EN for the starvation-forced loader slot.
// Latency: grants and mem_* are combinational in the request cycle; read data and its valid arrive one cycle after the grant.
// Backpressure: if_stall holds the fetch PC when fetch is not granted; the loader keeps ld_req up until it sees ld_gnt.
module imem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              ld_done,
  output logic              cpu_run,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("imem_arbiter: STARVE_MAX must be in 1..255");
  end

  logic [0:0]        state_q, state_d;
  logic              if_rd_q, if_rd_d;
  logic              ld_rd_q, ld_rd_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              if_gnt;
  logic              force_ld;

`ifdef IMEM_ARB_FAIRNESS_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_q, starve_d;

  // A loader that has been denied STARVE_LIM times in RUN takes the next slot.
  assign force_ld = (state_q == ST_RUN) && ld_req && (starve_q == STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (ld_gnt) begin
      starve_d = '0;
    end else if ((state_q == ST_RUN) && ld_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_ld = 1'b0;
`endif

  always_comb begin
    if_gnt   = 1'b0;
    ld_gnt   = 1'b0;
    if_stall = 1'b0;
    if (state_q == ST_BOOT) begin
      ld_gnt   = ld_req;
      if_stall = if_req;
    end else begin
      ld_gnt   = ld_req & (~if_req | force_ld);
      if_gnt   = if_req & ~force_ld;
      if_stall = if_req & force_ld;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_BOOT) && ld_done) begin
      state_d = ST_RUN;
    end
  end

  assign cpu_run = (state_q == ST_RUN);

  assign mem_en    = if_gnt | ld_gnt;
  assign mem_we    = ld_gnt & ld_we;
  assign mem_addr  = ld_gnt ? ld_addr : (if_gnt ? if_addr : '0);
  assign mem_wdata = ld_gnt ? ld_wdata : '0;

  // At most one of these is set: grants are mutually exclusive and loader writes return nothing.
  assign if_rd_d = if_gnt;
  assign ld_rd_d = ld_gnt & ~ld_we;
  assign hold_d  = if_rd_q ? mem_rdata : hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      if_rd_q <= 1'b0;
      ld_rd_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if_rd_q <= if_rd_d;
      ld_rd_q <= ld_rd_d;
      hold_q  <= hold_d;
    end
  end

  assign if_valid  = if_rd_q;
  assign if_instr  = if_rd_q ? mem_rdata : hold_q;
  assign ld_rvalid = ld_rd_q;
  assign ld_rdata  = mem_rdata;

endmodule
